// File: rtl/divmmc_ctrl_if.sv
// divmmc_ctrl_if: synchronised Z80 bus toward the DivMMC control engine,
// plus the mapping terms it returns to the memory-select decoder.
//   a, d                            CPU address / write data
//   n_m1, n_mreq, n_iorq, n_wr,
//   n_rfsh                          Z80 strobes, active low
//   conmem, mapram, automap, bank   mapping outputs from the engine
interface divmmc_ctrl_if;
    logic [15:0] a;
    logic [7:0]  d;
    logic        n_m1;
    logic        n_mreq;
    logic        n_iorq;
    logic        n_wr;
    logic        n_rfsh;
    logic        conmem;
    logic        mapram;
    logic        automap;
    logic [3:0]  bank;

    modport master (
        output a, d, n_m1, n_mreq, n_iorq, n_wr, n_rfsh,
        input  conmem, mapram, automap, bank
    );

    modport slave (
        input  a, d, n_m1, n_mreq, n_iorq, n_wr, n_rfsh,
        output conmem, mapram, automap, bank
    );
endinterface

// File: rtl/divmmc_ctrl.sv
// divmmc_ctrl: DivMMC control port and automap engine.
//   clk      system clock (bus already synchronised to it)
//   rst      asynchronous active-high reset
//   en       interface enable; low forces map outputs to 0 and automap to IDLE
//   trap_en  allows entry traps (ROM3 / 48K BASIC selected)
//   bus      slave side of divmmc_ctrl_if (CPU bus in, map terms out)
module divmmc_ctrl #(
    parameter logic [7:0] PORT_ADDR = 8'hE3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         trap_en,
    divmmc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_ON  = 2'd1,
        ON      = 2'd2,
        ARM_OFF = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        fetch_q;
    logic        iowr_q;
    logic        m1_q;
    logic        conmem_q;
    logic        mapram_q;
    logic [3:0]  bank_q;

    logic        fetch;
    logic        fetch_start;
    logic        iowr;
    logic        iowr_start;
    logic        m1_end;
    logic        cls_delayed;
    logic        cls_instant;
    logic        cls_exit;
    logic        unused_d;

    // Bus cycle decode and edge detection
    assign fetch       = !bus.n_m1 && !bus.n_mreq && bus.n_rfsh;
    assign fetch_start = fetch && !fetch_q;
    assign iowr        = !bus.n_iorq && !bus.n_wr && bus.n_m1 && (bus.a[7:0] == PORT_ADDR);
    assign iowr_start  = iowr && !iowr_q;
    assign m1_end      = !m1_q && bus.n_m1;

    // Address classification of the current opcode fetch
    always_comb begin
        cls_delayed = 1'b0;
        case (bus.a)
            16'h0000, 16'h0008, 16'h0038,
            16'h0066, 16'h04C6, 16'h0562: cls_delayed = trap_en;
            default:                      cls_delayed = 1'b0;
        endcase
    end

    assign cls_instant = trap_en && (bus.a[15:8] == 8'h3D);
    assign cls_exit    = (bus.a[15:3] == 13'h03FF);

    // Bits 5:4 of the control port carry no function
    assign unused_d = ^bus.d[5:4];

    // Bus history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q <= 1'b0;
            iowr_q  <= 1'b0;
            m1_q    <= 1'b1;
        end else begin
            fetch_q <= fetch;
            iowr_q  <= iowr;
            m1_q    <= bus.n_m1;
        end
    end

    // Control port; mapram is set-only until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conmem_q <= 1'b0;
            mapram_q <= 1'b0;
            bank_q   <= 4'h0;
        end else if (en && iowr_start) begin
            conmem_q <= bus.d[7];
            mapram_q <= mapram_q | bus.d[6];
            bank_q   <= bus.d[3:0];
        end
    end

    // Automap state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Automap next state; delayed entries and exits wait for the end of M1
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_start && cls_instant) begin
                        state_nxt = ON;
                    end else if (fetch_start && cls_delayed) begin
                        state_nxt = ARM_ON;
                    end
                end
                ARM_ON: begin
                    if (m1_end) begin
                        state_nxt = ON;
                    end
                end
                ON: begin
                    if (fetch_start && cls_exit) begin
                        state_nxt = ARM_OFF;
                    end
                end
                ARM_OFF: begin
                    if (fetch_start && cls_instant) begin
                        state_nxt = ON;
                    end else if (m1_end) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Map terms come from registers, masked only by the enable
    assign bus.conmem  = en && conmem_q;
    assign bus.mapram  = en && mapram_q;
    assign bus.automap = en && ((state == ON) || (state == ARM_OFF));
    assign bus.bank    = bank_q;
endmodule

// File: tb/tb_divmmc_ctrl.sv
// tb_divmmc_ctrl: table-driven scoreboard bench for divmmc_ctrl.
// Inputs are driven on the falling edge; the expected outputs after the next
// rising edge are queued at the same moment and compared 1 time unit after it.
module tb_divmmc_ctrl;
    localparam logic [4:0] IDL  = 5'b11111; // {n_m1,n_mreq,n_iorq,n_wr,n_rfsh}
    localparam logic [4:0] FET  = 5'b00111;
    localparam logic [4:0] IOW  = 5'b11001;
    localparam logic [4:0] IOM1 = 5'b01001;
    localparam logic [4:0] RFS  = 5'b00110;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [4:0]  strb;
        logic        trap_en;
        logic        en;
        logic [6:0]  exp; // {automap, conmem, mapram, bank}
    } vec_t;

    typedef struct {
        int         id;
        logic [6:0] exp;
    } chk_t;

    logic clk;
    logic rst;
    logic en;
    logic trap_en;

    divmmc_ctrl_if bus ();

    divmmc_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .trap_en (trap_en),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];
    chk_t exp_q[$];
    int   errors;
    int   checks;

    function automatic logic [6:0] e(input logic au, input logic cm, input logic mr,
                                     input logic [3:0] bk);
        return {au, cm, mr, bk};
    endfunction

    function automatic logic is_delayed(input logic [15:0] addr);
        return (addr == 16'h0000) || (addr == 16'h0008) || (addr == 16'h0038) ||
               (addr == 16'h0066) || (addr == 16'h04C6) || (addr == 16'h0562);
    endfunction

    function automatic logic is_instant(input logic [15:0] addr);
        return (addr >= 16'h3D00) && (addr <= 16'h3DFF);
    endfunction

    task automatic add(input logic [15:0] a, input logic [7:0] d, input logic [4:0] strb,
                       input logic tr, input logic enb, input logic [6:0] exp);
        vec_t v;
        v.a = a; v.d = d; v.strb = strb; v.trap_en = tr; v.en = enb; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic [4:0] strb,
                         input logic tr, input logic enb);
        bus.a      = a;
        bus.d      = d;
        bus.n_m1   = strb[4];
        bus.n_mreq = strb[3];
        bus.n_iorq = strb[2];
        bus.n_wr   = strb[1];
        bus.n_rfsh = strb[0];
        trap_en    = tr;
        en         = enb;
    endtask

    task automatic expect_next(input int id, input logic [6:0] exp);
        chk_t c;
        c.id = id; c.exp = exp;
        exp_q.push_back(c);
    endtask

    task automatic check_now(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {bus.automap, bus.conmem, bus.mapram, bus.bank};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {automap,conmem,mapram,bank}=%b required %b", name, act, exp);
        end
    endtask

    initial begin
        chk_t       c;
        logic [6:0] act;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(16'h0000, 8'h00, IDL, 1'b1, 1'b1);

        // Scoreboard: compare the oldest pending expectation after each rising edge
        fork
            forever begin
                @(posedge clk);
                #1;
                if (exp_q.size() > 0) begin
                    c = exp_q.pop_front();
                    act = {bus.automap, bus.conmem, bus.mapram, bus.bank};
                    checks++;
                    if (act !== c.exp) begin
                        errors++;
                        $display("FAIL vec%0d: got {automap,conmem,mapram,bank}=%b required %b",
                                 c.id, act, c.exp);
                    end
                end
            end
        join_none

        // Vector table: port writes, traps, exits, trap_en and en gating
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,0,0,4'h0));
        add(16'h00E3, 8'h8F, IOW,  1, 1, e(0,1,0,4'hF));
        add(16'h00E3, 8'h40, IOW,  1, 1, e(0,1,0,4'hF)); // held write: no second update
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,0,4'hF));
        add(16'h00E3, 8'h40, IOW,  1, 1, e(0,0,1,4'h0));
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,0,1,4'h0));
        add(16'h00E3, 8'h00, IOW,  1, 1, e(0,0,1,4'h0)); // mapram is sticky
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,0,1,4'h0));
        add(16'h00E7, 8'h8F, IOW,  1, 1, e(0,0,1,4'h0)); // other port
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,0,1,4'h0));
        add(16'h12E3, 8'h85, IOW,  1, 1, e(0,1,1,4'h5)); // high byte irrelevant
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));
        add(16'h00E3, 8'h00, IOM1, 1, 1, e(0,1,1,4'h5)); // n_m1 low: not a port write
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));
        for (int i = 0; i < 8; i++) add(16'h0038, 8'h00, FET, 1, 1, e(0,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 1, e(1,1,1,4'h5)); // end of M1 -> ON
        add(16'h0000, 8'h00, IDL,  1, 1, e(1,1,1,4'h5));
        add(16'h0038, 8'h00, FET,  1, 1, e(1,1,1,4'h5)); // entry keeps ON
        add(16'h0000, 8'h00, IDL,  1, 1, e(1,1,1,4'h5));
        for (int i = 0; i < 3; i++) add(16'h1FFB, 8'h00, FET, 1, 1, e(1,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));
        add(16'h1FFB, 8'h00, FET,  1, 1, e(0,1,1,4'h5)); // exit in IDLE
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));
        add(16'h3D2A, 8'h00, FET,  1, 1, e(1,1,1,4'h5)); // instant, inside M1
        add(16'h3D2A, 8'h00, FET,  1, 1, e(1,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 1, e(1,1,1,4'h5));
        add(16'h1FF8, 8'h00, FET,  1, 1, e(1,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));
        add(16'h0000, 8'h00, FET,  0, 1, e(0,1,1,4'h5)); // trap_en=0
        add(16'h0000, 8'h00, IDL,  0, 1, e(0,1,1,4'h5));
        add(16'h3D00, 8'h00, FET,  0, 1, e(0,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  0, 1, e(0,1,1,4'h5));
        add(16'h0038, 8'h00, RFS,  1, 1, e(0,1,1,4'h5)); // refresh is not a fetch
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));
        add(16'h3DFF, 8'h00, FET,  1, 1, e(1,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 1, e(1,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 0, e(0,0,0,4'h5)); // en=0 gates outputs
        add(16'h00E3, 8'h03, IOW,  1, 0, e(0,0,0,4'h5)); // write ignored
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5)); // back in IDLE, regs kept
        add(16'h0066, 8'h00, FET,  1, 1, e(0,1,1,4'h5));
        add(16'h0000, 8'h00, IDL,  1, 0, e(0,0,0,4'h5)); // en=0 cancels ARM_ON
        add(16'h0000, 8'h00, IDL,  1, 1, e(0,1,1,4'h5));

        @(negedge clk);
        check_now("reset_state", e(0,0,0,4'h0));
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].a, tbl[i].d, tbl[i].strb, tbl[i].trap_en, tbl[i].en);
            expect_next(i, tbl[i].exp);
        end

        // Asynchronous reset while ARM_ON mid-fetch
        @(negedge clk);
        drive(16'h0008, 8'h00, FET, 1'b1, 1'b1);
        expect_next(1000, e(0,1,1,4'h5));
        @(negedge clk);
        expect_next(1001, e(0,1,1,4'h5));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_now("async_reset", e(0,0,0,4'h0));
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0000, 8'h00, IDL, 1'b1, 1'b1);
        expect_next(1002, e(0,0,0,4'h0));
        @(negedge clk);
        drive(16'h1234, 8'h00, FET, 1'b1, 1'b1);
        expect_next(1003, e(0,0,0,4'h0));
        @(negedge clk);
        drive(16'h0000, 8'h00, IDL, 1'b1, 1'b1);
        expect_next(1004, e(0,0,0,4'h0));

        // Address sweep: only listed entries leave IDLE
        for (int ad = 0; ad < 16'h4000; ad++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            rst = 1'b0;
            drive(16'(ad), 8'h00, FET, 1'b1, 1'b1);
            expect_next(100000 + ad, e(is_instant(16'(ad)), 0, 0, 4'h0));
            @(negedge clk);
            drive(16'h0000, 8'h00, IDL, 1'b1, 1'b1);
            expect_next(200000 + ad,
                        e(is_instant(16'(ad)) || is_delayed(16'(ad)), 0, 0, 4'h0));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
